// File: rtl/uart_hex_frame_parser.sv
// UART ASCII-hex frame parser: assembles NCH channels of DW-bit words.
// Optional SOF sync, bad-char rejection, idle timeout, whole-frame commit.
module uart_hex_frame_parser #(
   parameter int         NCH         = 3,
   parameter int         DW          = 32,
   parameter int         USE_SOF     = 1,
   parameter logic [7:0] SOF_CHAR    = 8'h3A,
   parameter int         TIMEOUT_CYC = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   input  logic                rx_dataerr,
   input  logic                rx_frameerr,
   input  logic                clr,
   output logic [NCH*DW-1:0]   data_out,
   output logic                out_valid,
   output logic                busy,
   output logic                err,
   output logic [7:0]          err_cnt,
   output logic [15:0]         frame_cnt
);

   localparam int ND    = DW / 4;
   localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int NW    = (ND > 1) ? $clog2(ND) : 1;
   localparam int TW    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam int TLAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

   localparam logic [CW-1:0] CH_LAST  = CW'(NCH - 1);
   localparam logic [NW-1:0] NIB_LAST = NW'(ND - 1);

   typedef enum logic {
      S_HUNT,
      S_COLLECT
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       ch_q, ch_d;
   logic [NW-1:0]       nib_q, nib_d;
   logic [NCH*DW-1:0]   shadow_q, shadow_d;
   logic [NCH*DW-1:0]   data_q, data_d;
   logic                out_valid_q, out_valid_d;
   logic                err_q, err_d;
   logic [7:0]          err_cnt_q, err_cnt_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d;
   logic [TW-1:0]       timer_q, timer_d;

   logic [4:0] hv;
   logic       flag;
   logic       is_sof;
   logic       store;
   logic       abort;
   logic       resync;

   // {valid, value}
   function automatic logic [4:0] hex_dec(input logic [7:0] c);
      logic [4:0] r;
      r = '0;
      if (c >= 8'h30 && c <= 8'h39) begin
         r = {1'b1, c[3:0]};
      end else if ((c >= 8'h41 && c <= 8'h46) ||
                   (c >= 8'h61 && c <= 8'h66)) begin
         r = {1'b1, c[3:0] + 4'd9};
      end
      return r;
   endfunction

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      nib_d       = nib_q;
      shadow_d    = shadow_q;
      data_d      = data_q;
      out_valid_d = 1'b0;
      err_d       = 1'b0;
      err_cnt_d   = err_cnt_q;
      frame_cnt_d = frame_cnt_q;
      timer_d     = '0;
      store       = 1'b0;
      abort       = 1'b0;
      resync      = 1'b0;

      hv     = hex_dec(rx_data);
      flag   = rx_dataerr | rx_frameerr;
      is_sof = (USE_SOF != 0) && (rx_data == SOF_CHAR);

      case (state_q)
         S_HUNT: begin
            if (rx_valid && !flag) begin
               if (USE_SOF != 0) begin
                  if (is_sof) begin
                     state_d  = S_COLLECT;
                     ch_d     = '0;
                     nib_d    = '0;
                     shadow_d = '0;
                  end
               end else if (hv[4]) begin
                  state_d  = S_COLLECT;
                  ch_d     = '0;
                  nib_d    = '0;
                  shadow_d = '0;
                  store    = 1'b1;
               end
            end
         end
         S_COLLECT: begin
            if (rx_valid) begin
               if (flag) begin
                  abort = 1'b1;
               end else if (is_sof) begin
                  resync = 1'b1;
               end else if (hv[4]) begin
                  store = 1'b1;
               end else begin
                  abort = 1'b1;
               end
            end else if (TIMEOUT_CYC > 0) begin
               // a byte in the expiry cycle takes the branch above instead
               if (timer_q == TW'(TLAST)) begin
                  abort = 1'b1;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
         end
         default: state_d = S_HUNT;
      endcase

      if (store) begin
         for (int c = 0; c < NCH; c++) begin
            for (int n = 0; n < ND; n++) begin
               if (ch_d == CW'(c) && nib_d == NW'(n)) begin
                  shadow_d[c*DW + DW - 4 - 4*n +: 4] = hv[3:0];
               end
            end
         end
         if (ch_d == CH_LAST && nib_d == NIB_LAST) begin
            data_d      = shadow_d;
            out_valid_d = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = S_HUNT;
            ch_d        = '0;
            nib_d       = '0;
            shadow_d    = '0;
         end else if (nib_d == NIB_LAST) begin
            nib_d = '0;
            ch_d  = ch_d + CW'(1);
         end else begin
            nib_d = nib_d + NW'(1);
         end
      end

      if (abort || resync) begin
         err_d = 1'b1;
         if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
         shadow_d = '0;
         ch_d     = '0;
         nib_d    = '0;
      end
      if (abort) begin
         state_d = S_HUNT;
      end

      // clear wins over everything that happened this cycle
      if (clr) begin
         state_d     = S_HUNT;
         ch_d        = '0;
         nib_d       = '0;
         shadow_d    = '0;
         data_d      = '0;
         out_valid_d = 1'b0;
         err_d       = 1'b0;
         err_cnt_d   = '0;
         frame_cnt_d = '0;
         timer_d     = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_HUNT;
         ch_q        <= '0;
         nib_q       <= '0;
         shadow_q    <= '0;
         data_q      <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
         frame_cnt_q <= '0;
         timer_q     <= '0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         nib_q       <= nib_d;
         shadow_q    <= shadow_d;
         data_q      <= data_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
         err_cnt_q   <= err_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         timer_q     <= timer_d;
      end
   end

   assign data_out  = data_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q == S_COLLECT);
   assign err       = err_q;
   assign err_cnt   = err_cnt_q;
   assign frame_cnt = frame_cnt_q;

endmodule
